turf_event_fragmenter: RTL and testbench
========================================

TURF_EVENT_FRAGMENTER -- requirements
Module: turf_event_fragmenter

Interface
REQ-001 SHALL have parameter BUF_ADDR_BITS, default 10, fragment buffer depth 2^BUF_ADDR_BITS qwords.
REQ-002 SHALL have: aclk  input  1  sole clock.
REQ-003 SHALL have: areset  input  1  one clock; reset is synchronous and active-high.
REQ-004 SHALL have: s_evdata_tdata/tkeep/tlast/tvalid  input  64/8/1/1  event data stream; s_evdata_tready  output  1.
REQ-005 SHALL have: nfragment_count_i  input  10  fragment length in qwords minus one.
REQ-006 SHALL have: event_ip_i  input  32, event_port_i  input  16, event_open_i  input  1  destination and enable.
REQ-007 SHALL have: m_udphdr_tdata  output  64  {ip[63:32], port[31:16], length[15:0]}; m_udphdr_tvalid  output  1; m_udphdr_tready  input  1.
REQ-008 SHALL have: m_udpdata_tdata/tkeep/tlast/tvalid  output  64/8/1/1; m_udpdata_tready  input  1.
REQ-009 SHALL have: event_count_o  output  32  count of events transmitted.

Function
REQ-010 SHALL use states IDLE, FILL, HEADER, FRAGHDR, DRAIN, DISCARD.
REQ-011 IDLE: on s_evdata_tvalid, SHALL latch nfragment_count_i, event_ip_i, event_port_i; go to FILL if event_open_i=1, else DISCARD; accept no beat in IDLE.
REQ-012 Config inputs changing after latch (incl. event_open_i falling) SHALL not affect the current event.
REQ-013 FILL: s_evdata_tready=1; one beat per cycle written to buffer; qword counter increments.
REQ-014 Fragment SHALL close on the beat where count reaches latched nfragment+1 or on tlast, whichever first; next state HEADER.
REQ-015 Non-last input tkeep SHALL be treated as 8'hFF; last-beat tkeep is low-byte contiguous; stored for final output beat.
REQ-016 Length SHALL be 8*(qwords-1) + popcount(final tkeep), plus 8 when fragment header enabled; 16-bit.
REQ-017 HEADER: m_udphdr_tvalid=1 with latched ip/port/length, held stable until m_udphdr_tready; then FRAGHDR (macro on) or DRAIN.
REQ-018 FRAGHDR: emit one qword {event_count[63:32], frag_index[31:16], 15'b0, last_flag[0]}, tkeep 8'hFF, tlast=0, held until m_udpdata_tready.
REQ-019 DRAIN: emit buffered qwords in order, tvalid held until tready; tkeep 8'hFF except final beat; tlast on final beat only.
REQ-020 After DRAIN final beat: if fragment ended by tlast, event_count increments (wraps 2^32-1 to 0), frag_index clears, go IDLE; else frag_index increments, go FILL with latched config.
REQ-021 Input tlast on exactly the count boundary SHALL set last_flag=1 and end the event; no empty trailing fragment.
REQ-022 DISCARD: s_evdata_tready=1, beats dropped, exit to IDLE on accepted tlast; no output, no count change.
REQ-023 s_evdata_tready SHALL be 0 in HEADER, FRAGHDR, DRAIN; no buffer overlap.
REQ-024 Buffer read latency SHALL be hidden: no bubble between consecutive accepted output data beats.

Reset
REQ-025 On areset: state IDLE, all tvalid/tready outputs 0, event_count_o 0, frag_index 0, qword counter 0.
REQ-026 Reset mid-event SHALL abandon partial fragment; next input beat is treated as a new event start.

Configuration
REQ-027 Macro TURF_EVFRAG_FRAGHDR_EN defined: FRAGHDR state and +8 length term present.
REQ-028 Macro undefined: FRAGHDR skipped (HEADER goes to DRAIN), length excludes +8, payload is raw event data only.

Verification
REQ-029 Macro on, nfragment=127, open, 300-qword event, last tkeep 8'h0F -> 3 fragments, lengths 1032,1032,356; last_flag 0,0,1; frag_index 0,1,2; event_count_o=1.
REQ-030 nfragment=3, 4-qword event, full tkeep -> one fragment length 40, last_flag 1, no empty second fragment.
REQ-031 event_open_i=0 at start, 10-qword event -> no header/data output, tready=1 throughout, event_count_o unchanged.
REQ-032 m_udpdata_tready toggled randomly / m_udphdr_tready held low 20 cycles -> tdata stable while tvalid&!tready, no loss or duplication.
REQ-033 event_ip_i changed and event_open_i dropped mid-event -> all fragments of that event carry original ip/port.
REQ-034 areset pulsed during DRAIN -> all valids low next cycle, event_count_o=0, following event fragments correctly from frag_index 0.

Source files
------------

// File: rtl/turf_event_fragmenter_if.sv
// Stream bundle used on all three streaming ports of turf_event_fragmenter.
// The master drives tdata/tkeep/tlast/tvalid; the slave drives tready.
// On the UDP header stream only tdata/tvalid/tready carry meaning.
interface turf_event_fragmenter_if;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/turf_event_fragmenter.sv
// turf_event_fragmenter
// Splits an incoming event stream into UDP-sized fragments. Each fragment is
// stored in a block RAM, then a UDP header (ip/port/length) is emitted followed
// by the buffered payload. Input is stalled while a fragment is being sent.
// Optional feature: define TURF_EVFRAG_FRAGHDR_EN to prepend a one-qword
// fragment header {event_count, frag_index, 15'b0, last_flag} to each payload
// and to add 8 bytes to the reported UDP length.
module turf_event_fragmenter #(
    parameter int BUF_ADDR_BITS = 10
) (
    input  logic                           aclk,
    input  logic                           areset,
    turf_event_fragmenter_if.slave         s_evdata,
    input  logic [9:0]                     nfragment_count_i,
    input  logic [31:0]                    event_ip_i,
    input  logic [15:0]                    event_port_i,
    input  logic                           event_open_i,
    turf_event_fragmenter_if.master        m_udphdr,
    turf_event_fragmenter_if.master        m_udpdata,
    output logic [31:0]                    event_count_o
);

    // Counter must hold up to 1024 qwords (nfragment 1023 + 1). The buffer
    // depth must be at least nfragment+1 qwords for the configured traffic.
    localparam int CNT_W = (BUF_ADDR_BITS >= 10) ? BUF_ADDR_BITS + 1 : 11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HEADER,
        FRAGHDR,
        DRAIN,
        DISCARD
    } state_t;

    state_t                     state_reg;
    logic [9:0]                 nfrag_reg;
    logic [31:0]                ip_reg;
    logic [15:0]                port_reg;
    logic [CNT_W-1:0]           qword_cnt_reg;
    logic [7:0]                 last_keep_reg;
    logic                       ended_by_last_reg;
    logic [15:0]                length_reg;
    logic [15:0]                frag_index_reg;
    logic [31:0]                event_count_reg;
    logic                       s_tready_reg;
    logic                       hdr_tvalid_reg;
    logic                       dat_tvalid_reg;
    logic                       dat_tlast_reg;
    logic [7:0]                 dat_tkeep_reg;
    logic [BUF_ADDR_BITS-1:0]   rd_ptr_reg;
    logic [63:0]                rd_data_reg;
`ifdef TURF_EVFRAG_FRAGHDR_EN
    logic [63:0]                fraghdr_reg;
`endif

    logic [63:0]                buf_mem [0:(1<<BUF_ADDR_BITS)-1];

    logic                       beat_acc;
    logic                       dat_acc;
    logic [CNT_W-1:0]           cnt_inc;
    logic                       frag_full;
    logic [7:0]                 eff_keep;
    logic [3:0]                 keep_bit [8];
    logic [3:0]                 keep_pop;
    logic [15:0]                close_len;
    logic [BUF_ADDR_BITS-1:0]   rd_addr_next;

    assign beat_acc  = s_evdata.tvalid & s_tready_reg;
    assign dat_acc   = dat_tvalid_reg & m_udpdata.tready;
    assign cnt_inc   = qword_cnt_reg + CNT_W'(1);
    assign frag_full = (cnt_inc == (CNT_W'(nfrag_reg) + CNT_W'(1)));
    // Only the final beat's tkeep is meaningful; earlier beats are full qwords.
    assign eff_keep  = s_evdata.tlast ? s_evdata.tkeep : 8'hFF;

    for (genvar gi = 0; gi < 8; gi++) begin : g_keep_bits
        assign keep_bit[gi] = {3'b000, eff_keep[gi]};
    end

    // Byte count of the closing beat.
    always_comb begin
        keep_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            keep_pop = keep_pop + keep_bit[i];
        end
    end

    // qword_cnt_reg equals (qwords - 1) on the closing beat.
`ifdef TURF_EVFRAG_FRAGHDR_EN
    assign close_len = 16'({qword_cnt_reg, 3'b000}) + 16'(keep_pop) + 16'd8;
`else
    assign close_len = 16'({qword_cnt_reg, 3'b000}) + 16'(keep_pop);
`endif

    // Read address runs one beat ahead so the RAM output register always holds
    // the beat being presented: a consumed beat advances it, a stall re-reads
    // the same address, and outside DRAIN the first qword is pre-fetched.
    always_comb begin
        rd_addr_next = '0;
        if (state_reg == DRAIN) begin
            rd_addr_next = rd_ptr_reg;
            if (dat_acc && !dat_tlast_reg) begin
                rd_addr_next = rd_ptr_reg + BUF_ADDR_BITS'(1);
            end
        end
    end

    // Fragment buffer: write during FILL, registered read every cycle.
    always_ff @(posedge aclk) begin
        if (state_reg == FILL && beat_acc) begin
            buf_mem[qword_cnt_reg[BUF_ADDR_BITS-1:0]] <= s_evdata.tdata;
        end
        rd_data_reg <= buf_mem[rd_addr_next];
    end

    // Main control FSM with registered handshake outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg         <= IDLE;
            nfrag_reg         <= '0;
            ip_reg            <= '0;
            port_reg          <= '0;
            qword_cnt_reg     <= '0;
            last_keep_reg     <= 8'hFF;
            ended_by_last_reg <= 1'b0;
            length_reg        <= '0;
            frag_index_reg    <= '0;
            event_count_reg   <= '0;
            s_tready_reg      <= 1'b0;
            hdr_tvalid_reg    <= 1'b0;
            dat_tvalid_reg    <= 1'b0;
            dat_tlast_reg     <= 1'b0;
            dat_tkeep_reg     <= 8'hFF;
            rd_ptr_reg        <= '0;
`ifdef TURF_EVFRAG_FRAGHDR_EN
            fraghdr_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (s_evdata.tvalid) begin
                        nfrag_reg      <= nfragment_count_i;
                        ip_reg         <= event_ip_i;
                        port_reg       <= event_port_i;
                        qword_cnt_reg  <= '0;
                        frag_index_reg <= '0;
                        s_tready_reg   <= 1'b1;
                        state_reg      <= event_open_i ? FILL : DISCARD;
                    end
                end
                FILL: begin
                    if (beat_acc) begin
                        qword_cnt_reg <= cnt_inc;
                        if (s_evdata.tlast || frag_full) begin
                            s_tready_reg      <= 1'b0;
                            ended_by_last_reg <= s_evdata.tlast;
                            last_keep_reg     <= eff_keep;
                            length_reg        <= close_len;
                            rd_ptr_reg        <= '0;
                            hdr_tvalid_reg    <= 1'b1;
                            state_reg         <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (m_udphdr.tready) begin
                        hdr_tvalid_reg <= 1'b0;
                        dat_tvalid_reg <= 1'b1;
`ifdef TURF_EVFRAG_FRAGHDR_EN
                        fraghdr_reg    <= {event_count_reg, frag_index_reg,
                                           15'b0, ended_by_last_reg};
                        dat_tkeep_reg  <= 8'hFF;
                        dat_tlast_reg  <= 1'b0;
                        state_reg      <= FRAGHDR;
`else
                        dat_tlast_reg  <= (qword_cnt_reg == CNT_W'(1));
                        dat_tkeep_reg  <= (qword_cnt_reg == CNT_W'(1)) ?
                                          last_keep_reg : 8'hFF;
                        state_reg      <= DRAIN;
`endif
                    end
                end
`ifdef TURF_EVFRAG_FRAGHDR_EN
                FRAGHDR: begin
                    if (m_udpdata.tready) begin
                        dat_tlast_reg <= (qword_cnt_reg == CNT_W'(1));
                        dat_tkeep_reg <= (qword_cnt_reg == CNT_W'(1)) ?
                                         last_keep_reg : 8'hFF;
                        state_reg     <= DRAIN;
                    end
                end
`endif
                DRAIN: begin
                    if (m_udpdata.tready) begin
                        if (dat_tlast_reg) begin
                            dat_tvalid_reg <= 1'b0;
                            dat_tlast_reg  <= 1'b0;
                            dat_tkeep_reg  <= 8'hFF;
                            if (ended_by_last_reg) begin
                                event_count_reg <= event_count_reg + 32'd1;
                                frag_index_reg  <= '0;
                                state_reg       <= IDLE;
                            end else begin
                                frag_index_reg  <= frag_index_reg + 16'd1;
                                qword_cnt_reg   <= '0;
                                s_tready_reg    <= 1'b1;
                                state_reg       <= FILL;
                            end
                        end else begin
                            rd_ptr_reg    <= rd_ptr_reg + BUF_ADDR_BITS'(1);
                            dat_tlast_reg <= ((CNT_W'(rd_ptr_reg) + CNT_W'(2)) == qword_cnt_reg);
                            dat_tkeep_reg <= ((CNT_W'(rd_ptr_reg) + CNT_W'(2)) == qword_cnt_reg) ?
                                             last_keep_reg : 8'hFF;
                        end
                    end
                end
                DISCARD: begin
                    if (beat_acc && s_evdata.tlast) begin
                        s_tready_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign s_evdata.tready  = s_tready_reg;

    assign m_udphdr.tdata   = {ip_reg, port_reg, length_reg};
    assign m_udphdr.tkeep   = 8'hFF;
    assign m_udphdr.tlast   = 1'b1;
    assign m_udphdr.tvalid  = hdr_tvalid_reg;

`ifdef TURF_EVFRAG_FRAGHDR_EN
    assign m_udpdata.tdata  = (state_reg == FRAGHDR) ? fraghdr_reg : rd_data_reg;
`else
    assign m_udpdata.tdata  = rd_data_reg;
`endif
    assign m_udpdata.tkeep  = dat_tkeep_reg;
    assign m_udpdata.tlast  = dat_tlast_reg;
    assign m_udpdata.tvalid = dat_tvalid_reg;

    assign event_count_o    = event_count_reg;

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// Directed testbench for turf_event_fragmenter. Works with and without
// TURF_EVFRAG_FRAGHDR_EN defined; expectations adapt to the build.
module tb_turf_event_fragmenter;

`ifdef TURF_EVFRAG_FRAGHDR_EN
    localparam int HDR_EXTRA = 8;
`else
    localparam int HDR_EXTRA = 0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        aclk;
    logic        areset;
    logic [9:0]  nfragment_count_i;
    logic [31:0] event_ip_i;
    logic [15:0] event_port_i;
    logic        event_open_i;
    logic [31:0] event_count_o;

    turf_event_fragmenter_if s_ev ();
    turf_event_fragmenter_if m_hdr ();
    turf_event_fragmenter_if m_dat ();

    turf_event_fragmenter #(.BUF_ADDR_BITS(10)) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_evdata          (s_ev),
        .nfragment_count_i (nfragment_count_i),
        .event_ip_i        (event_ip_i),
        .event_port_i      (event_port_i),
        .event_open_i      (event_open_i),
        .m_udphdr          (m_hdr),
        .m_udpdata         (m_dat),
        .event_count_o     (event_count_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          to_count = 0;
    int          viol = 0;
    int          rmode = 0;
    logic [31:0] exp_evcount = 0;
    logic [63:0] hq[$];
    beat_t       dq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: record transfers and check stability while stalled.
    initial begin
        logic  hdr_pend = 1'b0;
        logic  dat_pend = 1'b0;
        logic [63:0] hdr_prev = '0;
        beat_t dat_prev = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                hdr_pend = 1'b0;
                dat_pend = 1'b0;
            end else begin
                if (hdr_pend && !(m_hdr.tvalid && m_hdr.tdata === hdr_prev)) viol++;
                if (dat_pend && !(m_dat.tvalid && {m_dat.tdata, m_dat.tkeep, m_dat.tlast} === dat_prev)) viol++;
                if (m_hdr.tvalid && m_hdr.tready) hq.push_back(m_hdr.tdata);
                if (m_dat.tvalid && m_dat.tready) dq.push_back({m_dat.tdata, m_dat.tkeep, m_dat.tlast});
                hdr_pend = m_hdr.tvalid && !m_hdr.tready;
                dat_pend = m_dat.tvalid && !m_dat.tready;
                hdr_prev = m_hdr.tdata;
                dat_prev = {m_dat.tdata, m_dat.tkeep, m_dat.tlast};
            end
        end
    end

    // Output ready generation: mode 0 always ready, mode 1 random data ready
    // and header ready held low for 20 cycles of valid.
    initial begin
        int hw = 0;
        m_hdr.tready = 1'b1;
        m_dat.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (rmode == 0) begin
                m_hdr.tready = 1'b1;
                m_dat.tready = 1'b1;
                hw = 0;
            end else begin
                m_dat.tready = 1'($urandom_range(0, 1));
                if (m_hdr.tvalid) hw++;
                else hw = 0;
                m_hdr.tready = (hw > 20);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_event(input int nq, input logic [7:0] lkeep, input logic [31:0] base,
                              input int chg_at, output int stalls);
        stalls = 0;
        for (int i = 0; i < nq; i++) begin
            int w;
            s_ev.tvalid = 1'b1;
            s_ev.tdata  = {base, 32'(i)};
            s_ev.tkeep  = (i == nq - 1) ? lkeep : ((i % 2 == 1) ? 8'h00 : 8'h5A);
            s_ev.tlast  = (i == nq - 1);
            if (i == chg_at) begin
                event_ip_i        = 32'hDEAD_BEEF;
                event_port_i      = 16'h9999;
                event_open_i      = 1'b0;
                nfragment_count_i = 10'd1;
            end
            w = 0;
            forever begin
                @(negedge aclk);
                if (s_ev.tready) break;
                w++;
                if (w > 5000) begin
                    to_count++;
                    break;
                end
            end
            @(posedge aclk);
            #1;
            if (i > 0) stalls += w;
        end
        s_ev.tvalid = 1'b0;
        s_ev.tlast  = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (dq.size() < n && c < 20000) begin
            @(negedge aclk);
            c++;
        end
        if (dq.size() < n) to_count++;
        repeat (5) @(negedge aclk);
    endtask

    task automatic check_event(input string name, input int nq, input int nfrag,
                               input logic [7:0] lkeep, input logic [31:0] ip,
                               input logic [15:0] port, input logic [31:0] base);
        int fsz = nfrag + 1;
        int nfr = (nq + fsz - 1) / fsz;
        int pos = 0;
        int nbeats = nq + nfr * (HDR_EXTRA / 8);
        chk($sformatf("%s hdr_count", name), 64'(hq.size()), 64'(nfr));
        chk($sformatf("%s beat_count", name), 64'(dq.size()), 64'(nbeats));
        for (int f = 0; f < nfr; f++) begin
            int          q = (nq - pos < fsz) ? nq - pos : fsz;
            logic        last = (f == nfr - 1);
            logic [7:0]  k = last ? lkeep : 8'hFF;
            logic [15:0] len = 16'(8 * (q - 1) + $countones(k) + HDR_EXTRA);
            logic [63:0] h = (hq.size() > 0) ? hq.pop_front() : '0;
            beat_t       b;
            $display("%s frag %0d: hdr %h (expect len %0d)", name, f, h, len);
            chk($sformatf("%s f%0d hdr", name, f), h, {ip, port, len});
`ifdef TURF_EVFRAG_FRAGHDR_EN
            b = (dq.size() > 0) ? dq.pop_front() : '0;
            chk($sformatf("%s f%0d fraghdr", name, f), b.d, {exp_evcount, 16'(f), 15'b0, last});
            chk($sformatf("%s f%0d fraghdr_keep", name, f), 64'(b.k), 64'hFF);
            chk($sformatf("%s f%0d fraghdr_last", name, f), 64'(b.l), 64'd0);
`endif
            for (int j = 0; j < q; j++) begin
                b = (dq.size() > 0) ? dq.pop_front() : '0;
                chk($sformatf("%s f%0d b%0d data", name, f, j), b.d, {base, 32'(pos + j)});
                chk($sformatf("%s f%0d b%0d keep", name, f, j), 64'(b.k),
                    64'((j == q - 1) ? k : 8'hFF));
                chk($sformatf("%s f%0d b%0d last", name, f, j), 64'(b.l), 64'(j == q - 1));
            end
            pos += q;
        end
        exp_evcount++;
        chk($sformatf("%s event_count", name), 64'(event_count_o), 64'(exp_evcount));
    endtask

    initial begin
        int st;
        int c;
        areset            = 1'b1;
        nfragment_count_i = 10'd0;
        event_ip_i        = '0;
        event_port_i      = '0;
        event_open_i      = 1'b0;
        s_ev.tvalid       = 1'b0;
        s_ev.tdata        = '0;
        s_ev.tkeep        = '0;
        s_ev.tlast        = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset hdr_tvalid", 64'(m_hdr.tvalid), 64'd0);
        chk("reset dat_tvalid", 64'(m_dat.tvalid), 64'd0);
        chk("reset s_tready", 64'(s_ev.tready), 64'd0);
        chk("reset event_count", 64'(event_count_o), 64'd0);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // A: single fragment exactly on the count boundary.
        nfragment_count_i = 10'd3; event_ip_i = 32'h0A00_0001; event_port_i = 16'h1234; event_open_i = 1'b1;
        send_event(4, 8'hFF, 32'hA0A0_0000, -1, st);
        wait_beats(4 + HDR_EXTRA / 8);
        check_event("A", 4, 3, 8'hFF, 32'h0A00_0001, 16'h1234, 32'hA0A0_0000);

        // B: 300-qword event in 128-qword fragments, partial last beat.
        nfragment_count_i = 10'd127; event_ip_i = 32'hC0A8_0102; event_port_i = 16'h4321;
        send_event(300, 8'h0F, 32'hB0B0_0000, -1, st);
        wait_beats(300 + 3 * HDR_EXTRA / 8);
        check_event("B", 300, 127, 8'h0F, 32'hC0A8_0102, 16'h4321, 32'hB0B0_0000);

        // C: closed event is discarded without backpressure or output.
        event_open_i = 1'b0;
        send_event(10, 8'hFF, 32'hC0C0_0000, -1, st);
        repeat (30) @(negedge aclk);
        $display("C discard: stalls %0d hdrs %0d beats %0d", st, hq.size(), dq.size());
        chk("C stalls", 64'(st), 64'd0);
        chk("C hdr_count", 64'(hq.size()), 64'd0);
        chk("C beat_count", 64'(dq.size()), 64'd0);
        chk("C event_count", 64'(event_count_o), 64'(exp_evcount));

        // D: backpressure on both outputs, config changed mid-event.
        rmode = 1;
        nfragment_count_i = 10'd4; event_ip_i = 32'h0101_0101; event_port_i = 16'h0F0F; event_open_i = 1'b1;
        send_event(13, 8'h01, 32'hD0D0_0000, 6, st);
        wait_beats(13 + 3 * HDR_EXTRA / 8);
        check_event("D", 13, 4, 8'h01, 32'h0101_0101, 16'h0F0F, 32'hD0D0_0000);
        rmode = 0;

        // E: reset while draining.
        nfragment_count_i = 10'd63; event_ip_i = 32'h0202_0202; event_port_i = 16'h2222; event_open_i = 1'b1;
        send_event(64, 8'hFF, 32'hE0E0_0000, -1, st);
        c = 0;
        while (dq.size() < 3 && c < 2000) begin
            @(negedge aclk);
            c++;
        end
        if (dq.size() < 3) to_count++;
        @(posedge aclk);
        #1;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        $display("E reset: hdr_tvalid %b dat_tvalid %b count %0d", m_hdr.tvalid, m_dat.tvalid, event_count_o);
        chk("E hdr_tvalid", 64'(m_hdr.tvalid), 64'd0);
        chk("E dat_tvalid", 64'(m_dat.tvalid), 64'd0);
        chk("E s_tready", 64'(s_ev.tready), 64'd0);
        chk("E event_count", 64'(event_count_o), 64'd0);
        areset = 1'b0;
        hq.delete();
        dq.delete();
        exp_evcount = 0;
        @(posedge aclk);
        #1;

        // F: fresh event after reset starts at fragment 0.
        nfragment_count_i = 10'd1; event_ip_i = 32'h0303_0303; event_port_i = 16'h3333; event_open_i = 1'b1;
        send_event(5, 8'h07, 32'hF0F0_0000, -1, st);
        wait_beats(5 + 3 * HDR_EXTRA / 8);
        check_event("F", 5, 1, 8'h07, 32'h0303_0303, 16'h3333, 32'hF0F0_0000);

        chk("stability", 64'(viol), 64'd0);
        chk("timeouts", 64'(to_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
